// File: rtl/charram_dram_ctrl.sv
// 4416 character-RAM DRAM initiator: arbitrates video fetch and CPU ports, sequences /RAS,/CAS,/WR,/RD.
// Registered strobes; data/ACK 5 edges after accept; back-to-back accesses every 4 MCLK.
module charram_dram_ctrl (
  input  logic        i_MCLK,
  input  logic        i_RST_n,
  input  logic        i_VID_REQ,
  input  logic [13:0] i_VID_ADDR,
  output logic [3:0]  o_VID_DATA,
  output logic        o_VID_VALID,
  output logic        o_VID_MISS,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WR,
  input  logic [13:0] i_CPU_ADDR,
  input  logic [3:0]  i_CPU_DIN,
  output logic [3:0]  o_CPU_DOUT,
  output logic        o_CPU_ACK,
  output logic [7:0]  o_ADDR,
  output logic [3:0]  o_DIN,
  input  logic [3:0]  i_DOUT,
  output logic        o_RAS_n,
  output logic        o_CAS_n,
  output logic        o_WR_n,
  output logic        o_RD_n
);
  typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_STB, S_CAPT} state_t;

  state_t      state_q, state_d;
  logic        vid_pend_q, vid_pend_d;
  logic [13:0] vid_addr_q, vid_addr_d;
  logic        vid_miss_q, vid_miss_d;
  logic        busy_q, busy_d;
  logic        rr_cpu_last_q, rr_cpu_last_d;
  logic [13:0] acc_addr_q, acc_addr_d;
  logic        acc_wr_q, acc_wr_d;
  logic        acc_vid_q, acc_vid_d;
  logic [3:0]  acc_din_q, acc_din_d;
  logic        ras_n_q, ras_n_d, cas_n_q, cas_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  din_q, din_d;
  logic [3:0]  vid_data_q, vid_data_d, cpu_dout_q, cpu_dout_d;
  logic        vid_vld_q, vid_vld_d, cpu_ack_q, cpu_ack_d;
  logic        cpu_rdy, at_accept, grant_vid, grant_cpu;

  always_comb begin
    // The ACK cycle's closing edge already frees the port, so a held request restarts there.
    cpu_rdy   = i_CPU_REQ && (!busy_q || cpu_ack_q);
    at_accept = (state_q == S_IDLE) || (state_q == S_CAPT);
    grant_vid = at_accept && vid_pend_q && (!cpu_rdy || rr_cpu_last_q);
    grant_cpu = at_accept && cpu_rdy && !grant_vid;

    state_d       = state_q;
    vid_pend_d    = vid_pend_q;
    vid_addr_d    = vid_addr_q;
    vid_miss_d    = 1'b0;
    busy_d        = busy_q;
    rr_cpu_last_d = rr_cpu_last_q;
    acc_addr_d    = acc_addr_q;
    acc_wr_d      = acc_wr_q;
    acc_vid_d     = acc_vid_q;
    acc_din_d     = acc_din_q;
    vid_data_d    = vid_data_q;
    cpu_dout_d    = cpu_dout_q;
    vid_vld_d     = 1'b0;
    cpu_ack_d     = 1'b0;

    if (grant_vid) vid_pend_d = 1'b0;
    if (i_VID_REQ) begin
      vid_pend_d = 1'b1;
      vid_addr_d = i_VID_ADDR;
      vid_miss_d = vid_pend_q && !grant_vid;
    end

    if (grant_cpu)      busy_d = 1'b1;
    else if (cpu_ack_q) busy_d = 1'b0;

    if (grant_vid) begin
      acc_addr_d    = vid_addr_q;
      acc_wr_d      = 1'b0;
      acc_vid_d     = 1'b1;
      rr_cpu_last_d = 1'b0;
    end else if (grant_cpu) begin
      acc_addr_d    = i_CPU_ADDR;
      acc_wr_d      = i_CPU_WR;
      acc_din_d     = i_CPU_DIN;
      acc_vid_d     = 1'b0;
      rr_cpu_last_d = 1'b1;
    end

    if (state_q == S_CAPT) begin
      if (acc_vid_q) begin
        vid_data_d = i_DOUT;
        vid_vld_d  = 1'b1;
      end else begin
        cpu_ack_d = 1'b1;
        if (!acc_wr_q) cpu_dout_d = i_DOUT;
      end
    end

    case (state_q)
      S_IDLE, S_CAPT: state_d = (grant_vid || grant_cpu) ? S_ROW : S_IDLE;
      S_ROW:          state_d = S_COL;
      S_COL:          state_d = S_STB;
      S_STB:          state_d = S_CAPT;
      default:        state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they change on the same edge as the state.
    ras_n_d = 1'b1;
    cas_n_d = 1'b1;
    wr_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_d)
      S_ROW: begin
        ras_n_d = 1'b0;
        addr_d  = acc_addr_d[7:0];
      end
      S_COL: begin
        ras_n_d = 1'b0;
        cas_n_d = 1'b0;
        addr_d  = {1'b0, acc_addr_d[13:8], 1'b0};
      end
      S_STB: begin
        ras_n_d = 1'b0;
        cas_n_d = 1'b0;
        addr_d  = {1'b0, acc_addr_d[13:8], 1'b0};
        if (acc_wr_d) begin
          wr_n_d = 1'b0;
          din_d  = acc_din_d;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q       <= S_IDLE;
      vid_pend_q    <= 1'b0;
      vid_addr_q    <= '0;
      vid_miss_q    <= 1'b0;
      busy_q        <= 1'b0;
      rr_cpu_last_q <= 1'b1;
      acc_addr_q    <= '0;
      acc_wr_q      <= 1'b0;
      acc_vid_q     <= 1'b0;
      acc_din_q     <= '0;
      ras_n_q       <= 1'b1;
      cas_n_q       <= 1'b1;
      wr_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      addr_q        <= '0;
      din_q         <= '0;
      vid_data_q    <= '0;
      cpu_dout_q    <= '0;
      vid_vld_q     <= 1'b0;
      cpu_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      vid_pend_q    <= vid_pend_d;
      vid_addr_q    <= vid_addr_d;
      vid_miss_q    <= vid_miss_d;
      busy_q        <= busy_d;
      rr_cpu_last_q <= rr_cpu_last_d;
      acc_addr_q    <= acc_addr_d;
      acc_wr_q      <= acc_wr_d;
      acc_vid_q     <= acc_vid_d;
      acc_din_q     <= acc_din_d;
      ras_n_q       <= ras_n_d;
      cas_n_q       <= cas_n_d;
      wr_n_q        <= wr_n_d;
      rd_n_q        <= rd_n_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      vid_data_q    <= vid_data_d;
      cpu_dout_q    <= cpu_dout_d;
      vid_vld_q     <= vid_vld_d;
      cpu_ack_q     <= cpu_ack_d;
    end
  end

  assign o_VID_DATA  = vid_data_q;
  assign o_VID_VALID = vid_vld_q;
  assign o_VID_MISS  = vid_miss_q;
  assign o_CPU_DOUT  = cpu_dout_q;
  assign o_CPU_ACK   = cpu_ack_q;
  assign o_ADDR      = addr_q;
  assign o_DIN       = din_q;
  assign o_RAS_n     = ras_n_q;
  assign o_CAS_n     = cas_n_q;
  assign o_WR_n      = wr_n_q;
  assign o_RD_n      = rd_n_q;
endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Bench for charram_dram_ctrl: 4416 memory model, directed timing scenarios and a randomized
// two-port phase, with read data checked by a queue-based scoreboard against a flat memory model.
module tb_charram_dram_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [13:0] vid_addr = '0, cpu_addr = '0;
  logic [3:0]  cpu_din = '0, dram_dout = '0;
  logic [3:0]  o_VID_DATA, o_CPU_DOUT, o_DIN;
  logic        o_VID_VALID, o_VID_MISS, o_CPU_ACK;
  logic [7:0]  o_ADDR;
  logic        o_RAS_n, o_CAS_n, o_WR_n, o_RD_n;

  always #5 clk = ~clk;

  charram_dram_ctrl dut (
    .i_MCLK(clk), .i_RST_n(rst_n),
    .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr), .o_VID_DATA(o_VID_DATA),
    .o_VID_VALID(o_VID_VALID), .o_VID_MISS(o_VID_MISS),
    .i_CPU_REQ(cpu_req), .i_CPU_WR(cpu_wr), .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
    .o_CPU_DOUT(o_CPU_DOUT), .o_CPU_ACK(o_CPU_ACK),
    .o_ADDR(o_ADDR), .o_DIN(o_DIN), .i_DOUT(dram_dout),
    .o_RAS_n(o_RAS_n), .o_CAS_n(o_CAS_n), .o_WR_n(o_WR_n), .o_RD_n(o_RD_n)
  );

  int tests = 0, fails = 0, cyc = 0;
  int vid_cnt = 0, ack_cnt = 0, miss_cnt = 0;
  logic [3:0] ref_mem [0:16383];
  logic [3:0] dram_mem [0:16383];
  logic [3:0] vid_q[$];
  logic [3:0] cpu_q[$];
  logic [3:0] cpu_last_rd = '0;
  int         ras_cyc[$];
  logic [7:0] ras_row[$];
  logic       ras_prev = 1'b1;
  bit         hold_mode = 1'b0;
  logic [3:0] hold_val = '0;
  logic [7:0] d_row = '0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // 4416 model: row latched while RAS low/CAS high, column access while both low.
  always @(posedge clk) begin
    cyc++;
    if (!o_RAS_n && o_CAS_n) d_row = o_ADDR;
    if (!o_RAS_n && !o_CAS_n) begin
      if (!o_WR_n) dram_mem[{o_ADDR[6:1], d_row}] = o_DIN;
      if (!o_RD_n) dram_dout <= dram_mem[{o_ADDR[6:1], d_row}];
    end
  end

  // Monitor/scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_VID_VALID) begin
        vid_cnt++;
        if (vid_q.size() == 0) flag_fail("vid_unexpected_valid");
        else check("vid_data", o_VID_DATA, vid_q.pop_front());
      end
      if (o_CPU_ACK) begin
        ack_cnt++;
        if (hold_mode) check("cpu_hold_dout", o_CPU_DOUT, hold_val);
        else if (cpu_q.size() == 0) flag_fail("cpu_unexpected_ack");
        else check("cpu_dout", o_CPU_DOUT, cpu_q.pop_front());
      end
      if (o_VID_MISS) miss_cnt++;
      if (!o_RAS_n && ras_prev) begin
        ras_cyc.push_back(cyc);
        ras_row.push_back(o_ADDR);
      end
    end
    ras_prev = o_RAS_n;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic wr, input logic [13:0] a, input logic [3:0] d,
                            output int lat, output logic [7:0] row, output logic [7:0] col,
                            output int wr_lo);
    int ras_e;
    ras_e = 0; lat = -1; row = '0; col = '0; wr_lo = 0;
    cpu_wr = wr; cpu_addr = a; cpu_din = d; cpu_req = 1'b1;
    cpu_q.push_back(wr ? cpu_last_rd : ref_mem[a]);
    if (wr) ref_mem[a] = d;
    else cpu_last_rd = ref_mem[a];
    for (int e = 1; e <= 40; e++) begin
      step();
      if (!o_RAS_n && o_CAS_n) begin
        if (ras_e == 0) ras_e = e;
        row = o_ADDR;
      end
      if (!o_CAS_n) col = o_ADDR;
      if (!o_WR_n) wr_lo++;
      if (o_CPU_ACK) begin
        lat = e - ras_e + 1;
        break;
      end
    end
    cpu_req = 1'b0;
    if (lat < 0) flag_fail("cpu_ack_timeout");
  endtask

  task automatic vid_pulse(input logic [13:0] a);
    vid_addr = a; vid_req = 1'b1;
    vid_q.push_back(ref_mem[a]);
    step();
    vid_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wlo, ras_e, rh, nack, bad, a1, a2, r2, acks_first, ack0, miss0, v0;
    logic [7:0] row, col;
    logic rp;

    for (int i = 0; i < 16384; i++) begin
      ref_mem[i] = 4'($urandom);
      dram_mem[i] = ref_mem[i];
    end
    ref_mem[14'h0101] = 4'h7; dram_mem[14'h0101] = 4'h7;
    ref_mem[14'h0010] = 4'h3; dram_mem[14'h0010] = 4'h3;
    ref_mem[14'h0020] = 4'hC; dram_mem[14'h0020] = 4'hC;

    // Reset state
    repeat (3) step();
    check("rst_strobes", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}, 4'hF);
    check("rst_addr", o_ADDR, 0);
    check("rst_din", o_DIN, 0);
    check("rst_data", {o_VID_DATA, o_CPU_DOUT}, 0);
    check("rst_pulses", {o_VID_VALID, o_CPU_ACK, o_VID_MISS}, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // CPU write then read of 0x2A5C
    cpu_access(1'b1, 14'h2A5C, 4'hB, lat, row, col, wlo);
    check("wr_row_addr", row, 8'h5C);
    check("wr_col_addr", col, 8'h54);
    check("wr_n_low_cycles", wlo, 1);
    check("wr_ack_latency", lat, 5);
    step();
    cpu_access(1'b0, 14'h2A5C, 4'h0, lat, row, col, wlo);
    check("rd_row_addr", row, 8'h5C);
    check("rd_col_addr", col, 8'h54);
    check("rd_wr_n_low_cycles", wlo, 0);
    check("rd_ack_latency", lat, 5);
    check("rd_dout", o_CPU_DOUT, 4'hB);
    step();
    check("ack_one_cycle", o_CPU_ACK, 0);

    // Video read latency
    vid_pulse(14'h0101);
    ras_e = 0; lat = -1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (!o_RAS_n && ras_e == 0) ras_e = e;
      if (o_VID_VALID) begin
        lat = e - ras_e + 1;
        check("vid_data_direct", o_VID_DATA, 4'h7);
        break;
      end
    end
    check("vid_latency", lat, 5);
    step();
    check("vid_valid_one_cycle", o_VID_VALID, 0);
    repeat (2) step();

    // Contention: CPU held, video pulsed; accesses must alternate every 4 cycles
    ras_cyc.delete(); ras_row.delete();
    miss0 = miss_cnt; hold_mode = 1'b1; hold_val = 4'hB;
    cpu_wr = 1'b0; cpu_addr = 14'h2A5C; cpu_req = 1'b1; vid_addr = 14'h0101;
    nack = 0; rh = 0;
    for (int k = 0; k < 44; k++) begin
      vid_req = (k == 0) || ((k % 8 == 4) && k <= 20);
      if (vid_req) vid_q.push_back(4'h7);
      step();
      if (o_CPU_ACK) nack++;
      if (nack == 4) cpu_req = 1'b0;
      if (k <= 30 && o_RAS_n) rh++;
    end
    vid_req = 1'b0;
    @(negedge clk);
    hold_mode = 1'b0;
    check("cont_access_count", ras_row.size(), 8);
    bad = 0;
    for (int i = 0; i < ras_row.size(); i++) begin
      if (ras_row[i] != ((i % 2 == 0) ? 8'h5C : 8'h01)) bad++;
      if (i > 0 && ras_cyc[i] - ras_cyc[i-1] != 4) bad++;
    end
    check("cont_alternate_every4", bad, 0);
    check("cont_ras_high_cycles", rh, 7);
    check("cont_no_miss", miss_cnt - miss0, 0);

    // Video overwrite while CPU access in flight
    step();
    ras_row.delete();
    miss0 = miss_cnt; v0 = vid_cnt;
    cpu_wr = 1'b1; cpu_addr = 14'h0444; cpu_din = 4'h6; cpu_req = 1'b1;
    cpu_q.push_back(cpu_last_rd); ref_mem[14'h0444] = 4'h6;
    step();
    vid_addr = 14'h0010; vid_req = 1'b1;
    step();
    vid_addr = 14'h0020;
    step();
    vid_req = 1'b0;
    vid_q.push_back(ref_mem[14'h0020]);
    for (int e = 0; e < 16; e++) begin
      step();
      if (o_CPU_ACK) cpu_req = 1'b0;
    end
    @(negedge clk);
    check("ovr_miss_pulses", miss_cnt - miss0, 1);
    check("ovr_vid_fetches", vid_cnt - v0, 1);
    check("ovr_fetched_row", (ras_row.size() == 2) ? ras_row[1] : 8'hFF, 8'h20);

    // CPU hold-over: second access starts on the edge after the ACK cycle
    step();
    cpu_wr = 1'b0; cpu_addr = 14'h2A5C; cpu_req = 1'b1;
    cpu_q.push_back(4'hB); cpu_q.push_back(4'hB); cpu_last_rd = 4'hB;
    a1 = -1; a2 = -1; r2 = -1; acks_first = 0; rp = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (!o_RAS_n && rp && a1 > 0 && r2 < 0) r2 = e;
      rp = o_RAS_n;
      if (o_CPU_ACK) begin
        if (e <= 9) acks_first++;
        if (a1 < 0) a1 = e;
        else if (a2 < 0) a2 = e;
      end
      if (a2 > 0) begin
        cpu_req = 1'b0;
        break;
      end
    end
    cpu_req = 1'b0;
    check("hold_ack1_edge", a1, 5);
    check("hold_second_row_edge", r2, 6);
    check("hold_ack2_edge", a2, 10);
    check("hold_single_ack_first", acks_first, 1);
    repeat (2) step();

    // Reset asserted during STB of a write
    cpu_wr = 1'b1; cpu_addr = 14'h1111; cpu_din = 4'hF; cpu_req = 1'b1;
    wlo = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (!o_WR_n) begin
        wlo = 1;
        break;
      end
    end
    check("midrst_reached_stb", wlo, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_strobes_async", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}, 4'hF);
    cpu_req = 1'b0;
    vid_q.delete(); cpu_q.delete(); cpu_last_rd = '0;
    repeat (2) step();
    rst_n = 1'b1;
    ack0 = ack_cnt;
    repeat (8) step();
    @(negedge clk);
    check("midrst_no_ack", ack_cnt - ack0, 0);
    check("midrst_dout_cleared", o_CPU_DOUT, 0);

    // Round-robin after reset: video wins when both are pending
    step();
    ras_row.delete();
    vid_pulse(14'h0101);
    cpu_access(1'b0, 14'h2A5C, 4'h0, lat, row, col, wlo);
    repeat (6) step();
    check("rr_rst_first_video", (ras_row.size() >= 1) ? ras_row[0] : 8'hFF, 8'h01);
    check("rr_rst_second_cpu", (ras_row.size() >= 2) ? ras_row[1] : 8'hFF, 8'h5C);

    // Randomized two-port traffic: CPU in lower half, video in (never-written) upper half
    miss0 = miss_cnt;
    fork
      begin
        int l, w;
        logic [7:0] r, c;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) step();
          cpu_access(1'($urandom), {1'b0, 13'($urandom)}, 4'($urandom), l, r, c, w);
        end
      end
      begin
        int vb;
        bit got;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 5)) step();
          vb = vid_cnt;
          vid_pulse({1'b1, 13'($urandom)});
          got = 1'b0;
          for (int t = 0; t < 40; t++) begin
            step();
            if (vid_cnt > vb) begin
              got = 1'b1;
              break;
            end
          end
          if (!got) flag_fail("rand_vid_timeout");
        end
      end
    join
    repeat (8) step();
    check("rand_no_miss", miss_cnt - miss0, 0);
    check("drain_vid_queue", vid_q.size(), 0);
    check("drain_cpu_queue", cpu_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/charram_dram_ctrl.md
# charram_dram_ctrl

Controller for the 4416-type 16K×4 character-RAM DRAM: the initiator side of the RAS/CAS multiplexed interface. It arbitrates a video pixel-fetch port and a CPU port, sequences row/column address, /RAS, /CAS, /WR and /RD, and returns read nibbles. It sits between the tile/sprite fetch logic plus the CPU bus interface and each charram DRAM instance.

## Interface
- No parameters; all widths are fixed to the 4416 organisation (14-bit address, 4-bit data).
- i_MCLK  in  1  master clock; all logic is on the rising edge.
- i_RST_n  in  1  asynchronous active-low reset.
- i_VID_REQ  in  1  one-cycle video fetch request strobe.
- i_VID_ADDR  in  14  video address, sampled with i_VID_REQ.
- o_VID_DATA  out  4  video read nibble, valid while o_VID_VALID is high.
- o_VID_VALID  out  1  one-cycle pulse marking video read data.
- o_VID_MISS  out  1  one-cycle pulse when a pending video request is overwritten.
- i_CPU_REQ  in  1  CPU request level, held until o_CPU_ACK.
- i_CPU_WR  in  1  CPU access type: 1 = write, 0 = read; sampled at accept.
- i_CPU_ADDR  in  14  CPU address, sampled at accept.
- i_CPU_DIN  in  4  CPU write nibble, sampled at accept.
- o_CPU_DOUT  out  4  CPU read nibble, valid while o_CPU_ACK is high.
- o_CPU_ACK  out  1  one-cycle completion pulse for both reads and writes.
- o_ADDR  out  8  multiplexed DRAM address.
- o_DIN  out  4  DRAM write data.
- i_DOUT  in  4  DRAM read data. The DRAM registers this on the edge where /RD is low.
- o_RAS_n, o_CAS_n, o_WR_n, o_RD_n  out  1 each  DRAM strobes, active low.

## Operation
- Address split: row = addr[7:0]; column = addr[13:8].
  - Row phase drives o_ADDR = addr[7:0].
  - Column phase drives o_ADDR = {1'b0, addr[13:8], 1'b0}.
- FSM states are IDLE, ROW, COL, STB and CAPT. All outputs are registered and take the values below during each state:
  - IDLE: all strobes high.
  - ROW: RAS_n=0, CAS_n=1, row address.
  - COL: RAS_n=0, CAS_n=0, column address.
  - STB: RAS_n=0, CAS_n=0, column address held. RD_n=0 for a read. For a write, WR_n=0 and o_DIN = data.
  - CAPT: all strobes high; this state is the precharge.
- Transitions:
  - ROW→COL→STB→CAPT is unconditional.
  - IDLE and CAPT move to ROW if an accepted request exists, otherwise to IDLE.
- Video pending register:
  - i_VID_REQ sets pending and loads i_VID_ADDR.
  - If pending is already set and not yet accepted, the address is overwritten and o_VID_MISS pulses.
  - A request arriving on the same edge the pending entry is accepted becomes the new pending entry with no miss.
- CPU port:
  - Accepted when i_CPU_REQ=1 and the port is not busy.
  - busy sets at accept and clears on the edge that ends the ACK cycle.
  - If REQ is still high after that edge, a new access starts.
- Arbitration at each accept point (IDLE, or end of CAPT):
  - If only one source is pending, it is served.
  - If both are pending, round-robin applies: the source served last loses. After reset, video wins first.
- Reads capture i_DOUT at the end of CAPT into o_VID_DATA or o_CPU_DOUT. That register holds its value until the next read for the same port.
- Writes produce o_CPU_ACK with o_CPU_DOUT unchanged. The video port is read-only.

## Timing
- Reset values:
  - State IDLE.
  - All four strobes 1.
  - o_ADDR=0, o_DIN=0, data outputs 0.
  - VALID, ACK and MISS 0.
  - Pending and busy cleared; round-robin favours video.
  - Reset mid-access forces strobes high immediately and issues no ACK or VALID.
- Access from accept edge E0:
  - ROW during E0–E1, COL during E1–E2, STB during E2–E3, CAPT during E3–E4.
  - The DRAM's output updates at E3.
  - Capture happens at E4; ACK/VALID are high during E4–E5.
- Request-to-data latency is 5 edges from the accept edge.
- Back-to-back throughput is one access per 4 MCLK. CAPT provides exactly one precharge cycle (RAS_n high) between accesses.
- A video request arriving mid-access waits at most one access when the CPU is not owed the next slot, or two accesses otherwise.

## Test plan
- Reset with strobes checked: hold i_RST_n=0 → RAS_n, CAS_n, WR_n and RD_n = 1, o_ADDR=0, no pulses. Assert reset during STB → strobes go high asynchronously and no ACK follows.
- CPU write then read: write addr 0x2A5C, data 0xB; then read 0x2A5C.
  - Row phase o_ADDR=0x5C; column phase o_ADDR=0x54.
  - WR_n is low for exactly 1 cycle.
  - The read returns o_CPU_DOUT=0xB with ACK 5 edges after accept.
- Video read latency: preload the DRAM model with 0x7 at 0x0101, pulse i_VID_REQ → o_VID_VALID one-cycle pulse with o_VID_DATA=0x7 at accept+5.
- Contention: i_CPU_REQ held and i_VID_REQ pulsed on the same edge, repeated continuously → accesses alternate video/CPU, one access per 4 cycles, RAS_n high exactly 1 cycle between accesses.
- Video overwrite: two i_VID_REQ pulses (addresses 0x0010 and 0x0020) while a CPU access is in progress → o_VID_MISS pulses once and only 0x0020 is fetched.
- CPU hold-over: keep i_CPU_REQ high through ACK → a second access starts at the edge after the ACK cycle, with no duplicate ACK within the first access.
